// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - collects an A/B/OP byte frame and issues it to the ALU
//
// Purpose: gathers three stream beats (A, B, OP byte) into registered ALU operands,
// holds them stable and hands the frame to the result-capture logic over a
// valid/ready issue handshake. Aborts a frame on an inter-beat timeout or an
// out-of-range OP byte, and counts completed issues.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    input byte stream (beat0=A, beat1=B, beat2=OP byte)
//   in_ready            a beat is accepted this cycle when in_valid is also high
//   a, b, op            registered operands / opcode to the ALU
//   out_valid/out_ready issue handshake towards the result-capture logic
//   frame_err           one-cycle pulse per aborted frame
//   issue_cnt           wrapping count of completed issues
module alu_operand_loader #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic [CNT_W-1:0]  issue_cnt
);

  localparam int GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT);

  typedef enum logic [1:0] {GET_A, GET_B, GET_OP, ISSUE} state_t;

  state_t           state, state_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic             accept, op_ok, expired;
  logic             load_a, load_b, load_op, err_n;

  // in_ready depends on state (and reset) only, never on in_valid.
  assign in_ready  = ~rst & (state != ISSUE);
  assign out_valid = (state == ISSUE);
  assign accept    = in_valid & in_ready;
  assign op_ok     = (in_data[DATA_W-1:2] == '0);
  assign expired   = (TIMEOUT > 0) && (gap == GAP_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= GET_A;
      gap       <= '0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      frame_err <= 1'b0;
      issue_cnt <= '0;
    end else begin
      state     <= state_n;
      gap       <= gap_n;
      frame_err <= err_n;
      if (load_a)  a  <= in_data;
      if (load_b)  b  <= in_data;
      if (load_op) op <= in_data[1:0];
      if (out_valid && out_ready) issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // Gap counter defaults to zero, so it is cleared on every accept and in
  // GET_A / ISSUE; it only counts idle edges inside a frame. An accept on the
  // expiry edge takes priority over the timeout.
  always_comb begin
    state_n = state;
    gap_n   = '0;
    err_n   = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    case (state)
      GET_A: begin
        if (accept) begin
          load_a  = 1'b1;
          state_n = GET_B;
        end
      end
      GET_B: begin
        if (accept) begin
          load_b  = 1'b1;
          state_n = GET_OP;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = GET_A;
        end else if (TIMEOUT > 0) begin
          gap_n = gap + 1'b1;
        end
      end
      GET_OP: begin
        if (accept) begin
          if (op_ok) begin
            load_op = 1'b1;
            state_n = ISSUE;
          end else begin
            err_n   = 1'b1;
            state_n = GET_A;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = GET_A;
        end else if (TIMEOUT > 0) begin
          gap_n = gap + 1'b1;
        end
      end
      ISSUE: begin
        if (out_ready) state_n = GET_A;
      end
      default: state_n = GET_A;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - self-checking bench for alu_operand_loader
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic [7:0] issue_cnt;

  alu_operand_loader #(.DATA_W(8), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int errs_seen = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [17:0] sb[$];

  typedef struct {
    logic [7:0] va, vb, vop;
    logic       err;
    logic [1:0] eop;
    logic [7:0] ec;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    case (o)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x << 4;
      default: return x ^ y;
    endcase
  endfunction

  // Scoreboard: pop on each issue handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) errs_seen++;
      if (frame_err && out_valid) chk("err_with_valid", 1, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_issue", 1, 0);
        else chk("sb_frame", {a, b, op}, sb.pop_front());
      end
    end
  end

  // Called and returns #1 after a rising edge; returns right after the accept edge.
  task automatic beat(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o);
    beat(x);
    beat(y);
    if (o[7:2] == 0) sb.push_back({x, y, o[1:0]});
    beat(o);
  endtask

  task automatic async_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_outs", {a, b, op, out_valid, frame_err, issue_cnt, in_ready}, 0);
    #2 rst = 1'b0;
    sb.delete();
    exp_cnt = 8'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [7:0] ra, rb;
    logic [1:0] ro;

    vecs[0] = '{8'h2A, 8'h15, 8'h00, 1'b0, 2'd0, 8'h3F};
    vecs[1] = '{8'h11, 8'h22, 8'h06, 1'b1, 2'd0, 8'h00};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 1'b0, 2'd3, 8'h03};
    vecs[3] = '{8'hF0, 8'h20, 8'h00, 1'b0, 2'd0, 8'h10};
    vecs[4] = '{8'h10, 8'h20, 8'h01, 1'b0, 2'd1, 8'hF0};
    vecs[5] = '{8'h0F, 8'h00, 8'h02, 1'b0, 2'd2, 8'hF0};
    vecs[6] = '{8'h33, 8'h33, 8'hFF, 1'b1, 2'd2, 8'h00};
    vecs[7] = '{8'h55, 8'hAA, 8'h03, 1'b0, 2'd3, 8'hFF};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset_state", {a, b, op, out_valid, frame_err, issue_cnt, in_ready}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_idle", in_ready, 1);

    // Table: normal frames, bad OP bytes, all four opcodes.
    foreach (vecs[i]) begin
      e0 = errs_seen;
      frame(vecs[i].va, vecs[i].vb, vecs[i].vop);
      chk("vec_out_valid", out_valid, !vecs[i].err);
      chk("vec_frame_err", frame_err, vecs[i].err);
      chk("vec_regs", {a, b, op}, {vecs[i].va, vecs[i].vb, vecs[i].eop});
      if (!vecs[i].err) begin
        chk("vec_alu_c", alu(a, b, op), vecs[i].ec);
        exp_cnt++;
      end
      @(posedge clk); #1;
      chk("vec_one_cycle", {out_valid, frame_err}, 0);
      chk("vec_issue_cnt", issue_cnt, exp_cnt);
      chk("vec_err_count", errs_seen - e0, vecs[i].err);
    end

    // Back-pressure: operands held while out_ready is low.
    out_ready = 1'b0;
    frame(8'hC8, 8'h50, 8'h01);
    repeat (5) begin
      chk("bp_hold", {out_valid, in_ready, a, b, op}, {1'b1, 1'b0, 8'hC8, 8'h50, 2'd1});
      @(posedge clk); #1;
    end
    chk("bp_cnt_hold", issue_cnt, exp_cnt);
    out_ready = 1'b1;
    exp_cnt++;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready, issue_cnt}, {1'b0, 1'b1, exp_cnt});

    // Timeout: 16 idle edges are tolerated in GET_B and GET_OP.
    e0 = errs_seen;
    beat(8'h10);
    repeat (16) begin @(posedge clk); #1; chk("to_no_err_b", frame_err, 0); end
    beat(8'h20);
    repeat (16) begin @(posedge clk); #1; chk("to_no_err_op", frame_err, 0); end
    sb.push_back({8'h10, 8'h20, 2'd2});
    beat(8'h02);
    chk("to_late_issue", out_valid, 1);
    exp_cnt++;
    @(posedge clk); #1;
    chk("to_late_errs", errs_seen - e0, 0);

    // Timeout: the 17th idle edge aborts the frame.
    beat(8'h10);
    repeat (16) begin @(posedge clk); #1; chk("to_before", frame_err, 0); end
    @(posedge clk); #1;
    chk("to_abort", {frame_err, in_ready, a}, {1'b1, 1'b1, 8'h10});
    @(posedge clk); #1;
    chk("to_abort_pulse", frame_err, 0);
    frame(8'h07, 8'h09, 8'h01);
    chk("to_recover", {out_valid, a, b, op}, {1'b1, 8'h07, 8'h09, 2'd1});
    exp_cnt++;
    @(posedge clk); #1;
    chk("to_recover_cnt", issue_cnt, exp_cnt);

    // Async reset in GET_OP, then in ISSUE.
    beat(8'hAB);
    beat(8'hCD);
    async_rst();
    frame(8'h02, 8'h03, 8'h00);
    chk("rst1_issue", {out_valid, a, b, op}, {1'b1, 8'h02, 8'h03, 2'd0});
    exp_cnt++;
    @(posedge clk); #1;
    chk("rst1_cnt", issue_cnt, exp_cnt);
    out_ready = 1'b0;
    frame(8'h44, 8'h55, 8'h03);
    @(posedge clk); #1;
    chk("rst2_in_issue", out_valid, 1);
    async_rst();
    chk("rst2_cnt", issue_cnt, 0);
    out_ready = 1'b1;
    frame(8'h81, 8'h01, 8'h01);
    chk("rst2_issue", {out_valid, a, b, op}, {1'b1, 8'h81, 8'h01, 2'd1});
    exp_cnt++;
    @(posedge clk); #1;
    chk("rst2_cnt_after", issue_cnt, exp_cnt);

    // 256 back-to-back frames: one issue every 4 cycles, counter wraps.
    async_rst();
    e0 = errs_seen;
    in_valid = 1'b1;
    for (int f = 0; f < 256; f++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 2'($urandom_range(0, 3));
      in_data = ra;           @(posedge clk); #1;
      in_data = rb;           @(posedge clk); #1;
      in_data = {6'b0, ro};
      sb.push_back({ra, rb, ro});
      @(posedge clk); #1;
      chk("b2b_issue", out_valid, 1);
      in_data = 8'($urandom);
      @(posedge clk); #1;
      if (f == 0) chk("b2b_cnt_first", issue_cnt, 1);
    end
    in_valid = 1'b0;
    chk("b2b_cnt_wrap", issue_cnt, 0);
    chk("b2b_no_err", errs_seen - e0, 0);

    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
